// File: rtl/mem_stage_pkg.sv
// Shared types and default sizing for the pipeline memory-access stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_DONE = 2'd2
    } mem_state_t;

    localparam int WORD_LEN    = 16;
    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Counts cycles spent waiting on the data memory; tc flags the last permitted wait cycle.
module mem_wait_counter
    import mem_stage_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: turns a one-cycle EX/MEM load/store into a req/ready access and stalls
// the pipeline until the data memory answers or the wait budget runs out.
//
//  state   | meaning
//  MS_IDLE | no access in flight; accepts a new load/store
//  MS_REQ  | mem_req held high, waiting for mem_ready
//  MS_DONE | one-cycle completion pulse, pipeline released
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD_W  = WORD_LEN,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [WORD_W-1:0] ex_alu_out,
    input  logic [WORD_W-1:0] ex_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] mem_out,
    output logic              mem_done,
    output logic              mem_stall,
    output logic              mem_err
);

    mem_state_t        state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] out_q;
    logic              err_q;
    logic              accept;
    logic              wait_tc;
    logic              unused_addr_hi;

    // Address bits above the memory width are dropped silently.
    assign unused_addr_hi = ^ex_alu_out[WORD_W-1:ADDR_W];

    assign accept = (state_q == MS_IDLE) && ex_valid && (ex_mem_read || ex_mem_write);

    mem_wait_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q != MS_REQ),
        .en  ((state_q == MS_REQ) && !mem_ready),
        .tc  (wait_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= MS_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MS_IDLE: if (accept) state_d = MS_REQ;
            MS_REQ:  if (mem_ready || wait_tc) state_d = MS_DONE;
            MS_DONE: state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (state_q == MS_REQ);
        mem_done  = (state_q == MS_DONE);
        mem_stall = (state_q == MS_REQ) || accept;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (accept) begin
                        we_q    <= ex_mem_write;
                        addr_q  <= ex_alu_out[ADDR_W-1:0];
                        wdata_q <= ex_wdata;
                        if (ex_mem_read && ex_mem_write)
                            err_q <= 1'b1;
                    end
                end
                MS_REQ: begin
                    if (mem_ready) begin
                        if (!we_q)
                            out_q <= mem_rdata;
                    end else if (wait_tc) begin
                        err_q <= 1'b1;
                        out_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_out   = out_q;
    assign mem_err   = err_q;

endmodule
